alu_bist: RTL
=============

# alu_bist

Built-in self-test controller for the 4-bit ALU logic units (XOR gate and siblings). It drives operand vectors into a combinational unit under test and compacts every result into a signature register. At the end of the run it compares the signature against a golden value and reports pass or fail. This is the in-silicon replacement for the directed vector benches used during bring-up: it sits between the lab top level and the ALU operand and result buses.

## Interface
- WIDTH, 4, operand/result/signature width (≥2)
- NUM_VECTORS, 16, vectors applied per run (1..2**WIDTH)
- GOLDEN_SIG, 4'b0000, expected final signature (WIDTH bits)

- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- abort  input  1  synchronous cancel of a run in progress
- result  input  WIDTH  combinational output of the unit under test
- op_a  output  WIDTH  operand A to the unit under test
- op_b  output  WIDTH  operand B to the unit under test
- busy  output  1  high while vectors are being applied
- done  output  1  high in DONE; run complete, pass valid
- pass  output  1  signature == GOLDEN_SIG; meaningful only while done=1
- signature  output  WIDTH  current signature register

## Operation
- State machine: IDLE, RUN, DONE.
- Registers: state, idx (vector index, clog2(NUM_VECTORS)+1 bits), sig (WIDTH bits), pass.
- IDLE: busy=0, done=0, op_a=op_b=0. If start=1: idx←0, sig←0, go to RUN.
- RUN: busy=1, op_a = idx[WIDTH-1:0], op_b = idx[WIDTH-1:0] rotated left by 1.
  - Every cycle: sig ← rotl(sig,1) XOR result.
  - If idx==NUM_VECTORS-1, go to DONE. Otherwise idx←idx+1.
- Signature update on the last RUN cycle: pass ← (rotl(sig,1) XOR result) == GOLDEN_SIG.
- DONE: done=1, busy=0, op_a=op_b=0. sig and pass hold. If start=1: idx←0, sig←0, pass←0, go to RUN.
- start in RUN is ignored.
- abort=1 in RUN: go to IDLE next edge, sig←0, pass←0. Abort has priority over the last-vector transition.
- abort in IDLE or DONE has no effect.
- Width rules: all XOR and rotate operations are WIDTH bits. idx wraps never, because the run ends at NUM_VECTORS-1.

## Timing
- Reset (rst_n=0, any time, including mid-run): state=IDLE, idx=0, sig=0, pass=0. Outputs are immediately busy=0, done=0, op_a=op_b=0, signature=0.
- Reset release: first edge with rst_n=1 may sample start.
- start sampled high at edge k puts RUN on edges k..k+NUM_VECTORS.
  - busy=1 and vector 0 are on op_a/op_b after edge k.
  - Vector i is presented after edge k+i, and result is sampled at edge k+i+1.
  - done=1 after edge k+NUM_VECTORS and holds until the next start or reset.
- Total latency from start to done is NUM_VECTORS+1 edges. busy stays high for exactly NUM_VECTORS cycles.
- The result path is combinational within one cycle. The unit under test must settle before the next edge.
- signature reflects the registered sig at all times, including in RUN.

## Test plan
- XOR unit attached, WIDTH=4, NUM_VECTORS=4, GOLDEN_SIG=4'b0101; pulse start.
  - op_a/op_b sequence: 0000/0000, 0001/0010, 0010/0100, 0011/0110.
  - signature sequence: 0000, 0011, 0000, 0101.
  - done=1 on the 5th edge, with pass=1 and busy=0.
- Same setup with result bit 0 forced to 1 → final signature ≠ 0101, pass=0, done=1.
- rst_n pulled low after 2 RUN cycles → busy, done, pass, op_a, op_b and signature all go to 0 immediately. A following start gives the full first-scenario sequence and pass=1.
- abort=1 on the 3rd RUN cycle → IDLE next edge, busy=0, done=0, signature=0. start pulses during RUN are ignored, with no restart and no idx reset.
- After pass=1 in DONE, pulse start again → done drops after the next edge and the identical run repeats to pass=1. Holding start in DONE continuously gives back-to-back runs.
- WIDTH=4, NUM_VECTORS=16, GOLDEN_SIG set to the value from a software model of the signature update → pass=1 after exactly 17 edges. op_a walks 0000..1111.

Source files
------------

// File: rtl/alu_bist_if.sv
// Bus between the BIST controller and its environment.
// master: lab top / bench side. It drives start, abort and result, and observes the rest.
// slave : alu_bist side. It drives the operands, status and signature.
interface alu_bist_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;      // begin a run (sampled in IDLE/DONE)
  logic             abort;      // cancel a run in progress
  logic [WIDTH-1:0] result;     // combinational output of the unit under test
  logic [WIDTH-1:0] op_a;       // operand A to the unit under test
  logic [WIDTH-1:0] op_b;       // operand B to the unit under test
  logic             busy;       // vectors being applied
  logic             done;       // run complete, pass valid
  logic             pass;       // final signature matched golden
  logic [WIDTH-1:0] signature;  // current signature register

  modport master (
    output start, abort, result,
    input  op_a, op_b, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, result,
    output op_a, op_b, busy, done, pass, signature
  );
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test controller for small combinational ALU units.
// The controller walks vector index idx over 0..NUM_VECTORS-1.
// It presents op_a = idx and op_b = rotl(idx, 1) to the unit under test.
// Each returned result is folded into the signature with sig <= rotl(sig, 1) ^ result.
// When the run ends, the final signature is compared with GOLDEN_SIG.
// Ports: clk, rst_n (async, active-low), bus (alu_bist_if.slave).
module alu_bist #(
  parameter int unsigned     WIDTH       = 4,
  parameter int unsigned     NUM_VECTORS = 16,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_bist_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_VECTORS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sig_next_c;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  // Next-state, signature compaction and registered output values
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sig_d      = sig_q;
    pass_d     = pass_q;
    sig_next_c = rotl1(sig_q) ^ bus.result;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          sig_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort wins over the last-vector transition
        if (bus.abort) begin
          idx_d   = '0;
          sig_d   = '0;
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          sig_d = sig_next_c;
          if (idx_q == LAST_IDX) begin
            pass_d  = (sig_next_c == GOLDEN_SIG);
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          idx_d   = '0;
          sig_d   = '0;
          pass_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        idx_d   = '0;
        sig_d   = '0;
        pass_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state, so the flops already hold the correct vector.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    op_a_d = busy_d ? WIDTH'(idx_d) : '0;
    op_b_d = busy_d ? rotl1(WIDTH'(idx_d)) : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;

endmodule
